// File: rtl/j_sertx_pkg.sv
// Shared types and sizing for the j_sertx serial audio transmitter.
package j_sertx_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int WIDTH_DEF = 16;

    // Width of the slot counter covering both channel words of one frame.
    function automatic int slot_width(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/j_sertx_div.sv
// Bit-clock generator: divides sys_clk into sck and flags sck falling edges.
module j_sertx_div (
    input  logic       sys_clk,
    input  logic       resl,
    input  logic       run,
    input  logic [7:0] sdiv,
    output logic       sck,
    output logic       bit_edge
);

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] sdiv_q, sdiv_d;
    logic       sck_q, sck_d;
    logic       tick;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        tick   = run && (cnt_q == sdiv_q);
        cnt_d  = cnt_q + 8'd1;
        sck_d  = sck_q;
        sdiv_d = sdiv_q;
        if (!run) begin
            cnt_d  = '0;
            sck_d  = 1'b0;
            sdiv_d = sdiv;
        end else if (tick) begin
            cnt_d  = '0;
            sck_d  = ~sck_q;
            sdiv_d = sdiv;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge sys_clk) begin
        if (!resl) begin
            cnt_q  <= '0;
            sck_q  <= 1'b0;
            sdiv_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            sck_q  <= sck_d;
            sdiv_q <= sdiv_d;
        end
    end

    assign sck      = sck_q;
    assign bit_edge = tick & sck_q;

endmodule

// File: rtl/j_sertx.sv
// Serial audio transmitter: per-channel holding registers shifted out MSB-first.
// Optional I2S one-bit data delay is enabled by defining J_SERTX_I2S_DELAY_EN.
module j_sertx
    import j_sertx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             sys_clk,
    input  logic             resl,
    input  logic [WIDTH-1:0] ldata,
    input  logic [WIDTH-1:0] rdata,
    input  logic             wr_l,
    input  logic             wr_r,
    input  logic             en,
    input  logic [7:0]       sdiv,
    input  logic             unr_clr,
    output logic             sck,
    output logic             ws,
    output logic             sdo,
    output logic             req_l,
    output logic             req_r,
    output logic             underrun
);

    localparam int             SW        = slot_width(WIDTH);
    localparam logic [SW-1:0]  SLOT_LAST = SW'(2 * WIDTH - 1);
    localparam logic [SW-1:0]  SLOT_LMAX = SW'(WIDTH - 1);
    localparam logic [SW-1:0]  SLOT_RBEG = SW'(WIDTH);

    state_e            state_q, state_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [WIDTH-1:0]  hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic              full_l_q, full_l_d, full_r_q, full_r_d;
    logic              unr_q, unr_d;
    logic              load_l, load_r, unr_set;
    logic              bit_edge;

    j_sertx_div u_div (
        .sys_clk  (sys_clk),
        .resl     (resl),
        .run      (state_q == ST_RUN),
        .sdiv     (sdiv),
        .sck      (sck),
        .bit_edge (bit_edge)
    );

`ifdef J_SERTX_I2S_DELAY_EN
    logic dly_q, dly_d;
`endif

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        shift_d  = shift_q;
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        full_l_d = full_l_q;
        full_r_d = full_r_q;
        load_l   = 1'b0;
        load_r   = 1'b0;
`ifdef J_SERTX_I2S_DELAY_EN
        dly_d    = dly_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_RUN;
                    slot_d  = '0;
                    load_l  = 1'b1;
                end
            end
            ST_RUN: begin
                if (bit_edge) begin
`ifdef J_SERTX_I2S_DELAY_EN
                    dly_d = shift_q[WIDTH-1];
`endif
                    // Frames always finish; en is only honoured at the frame boundary.
                    if (slot_q == SLOT_LAST) begin
                        slot_d = '0;
                        if (!en) begin
                            state_d = ST_IDLE;
                            shift_d = '0;
`ifdef J_SERTX_I2S_DELAY_EN
                            dly_d   = 1'b0;
`endif
                        end else begin
                            load_l = 1'b1;
                        end
                    end else begin
                        slot_d = slot_q + SW'(1);
                        if (slot_q == SLOT_LMAX) load_r = 1'b1;
                        else                     shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A coincident write lands after the load, so the load sees the old word.
        if (load_l) begin
            shift_d  = hold_l_q;
            full_l_d = 1'b0;
        end
        if (load_r) begin
            shift_d  = hold_r_q;
            full_r_d = 1'b0;
        end
        if (wr_l) begin
            hold_l_d = ldata;
            full_l_d = 1'b1;
        end
        if (wr_r) begin
            hold_r_d = rdata;
            full_r_d = 1'b1;
        end

        unr_set = (load_l & ~full_l_q) | (load_r & ~full_r_q);
        if (unr_set)      unr_d = 1'b1;
        else if (unr_clr) unr_d = 1'b0;
        else              unr_d = unr_q;
    end

    always_ff @(posedge sys_clk) begin
        if (!resl) begin
            state_q  <= ST_IDLE;
            slot_q   <= '0;
            shift_q  <= '0;
            hold_l_q <= '0;
            hold_r_q <= '0;
            full_l_q <= 1'b0;
            full_r_q <= 1'b0;
            unr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shift_q  <= shift_d;
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            full_l_q <= full_l_d;
            full_r_q <= full_r_d;
            unr_q    <= unr_d;
        end
    end

`ifdef J_SERTX_I2S_DELAY_EN
    always_ff @(posedge sys_clk) begin
        if (!resl) dly_q <= 1'b0;
        else       dly_q <= dly_d;
    end
    assign sdo = dly_q;
`else
    assign sdo = shift_q[WIDTH-1];
`endif

    assign ws       = (slot_q >= SLOT_RBEG);
    assign req_l    = ~full_l_q;
    assign req_r    = ~full_r_q;
    assign underrun = unr_q;

endmodule

// File: tb/tb_j_sertx.sv
// Directed self-checking bench for j_sertx (WIDTH = 16, sdiv = 1: 4 cycles per bit).
// Expected frames follow the J_SERTX_I2S_DELAY_EN setting of the build.
module tb_j_sertx;

    logic        sys_clk = 1'b0;
    logic        resl;
    logic [15:0] ldata, rdata;
    logic        wr_l, wr_r, en, unr_clr;
    logic [7:0]  sdiv;
    logic        sck, ws, sdo, req_l, req_r, underrun;

    int n_pass  = 0;
    int n_total = 0;

`ifdef J_SERTX_I2S_DELAY_EN
    localparam logic I2S = 1'b1;
`else
    localparam logic I2S = 1'b0;
`endif

    j_sertx dut (
        .sys_clk  (sys_clk),
        .resl     (resl),
        .ldata    (ldata),
        .rdata    (rdata),
        .wr_l     (wr_l),
        .wr_r     (wr_r),
        .en       (en),
        .sdiv     (sdiv),
        .unr_clr  (unr_clr),
        .sck      (sck),
        .ws       (ws),
        .sdo      (sdo),
        .req_l    (req_l),
        .req_r    (req_r),
        .underrun (underrun)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Expected 32 slot values of a frame; prev is the delayed bit left over from the previous frame.
    function automatic logic [31:0] exp_frame(input logic prev, input logic [15:0] l, input logic [15:0] r);
        if (I2S) return {prev, l, r[15:1]};
        else     return {l, r};
    endfunction

    // Called right after the edge that starts slot 0; returns 128 cycles later.
    task automatic capture_frame(input int drop_at, output logic [31:0] bits,
                                 output int ws_rise, output int sck_bad, output logic unr_last);
        bits = '0; ws_rise = -1; sck_bad = 0; unr_last = 1'b0;
        for (int k = 0; k < 128; k++) begin
            if (k == drop_at) en = 1'b0;
            if (k % 4 == 2) bits[31 - k / 4] = sdo;
            if (ws === 1'b1 && ws_rise < 0) ws_rise = k;
            if (sck !== ((k % 4) >= 2)) sck_bad++;
            if (k == 127) unr_last = underrun;
            step();
        end
    endtask

    task automatic test_reset();
        resl = 1'b0; en = 1'b1;
        repeat (3) step();
        n_total++; if (sck !== 1'b0) $display("FAIL reset_sck: got %b expected 0", sck); else n_pass++;
        n_total++; if (ws !== 1'b0) $display("FAIL reset_ws: got %b expected 0", ws); else n_pass++;
        n_total++; if (sdo !== 1'b0) $display("FAIL reset_sdo: got %b expected 0", sdo); else n_pass++;
        n_total++; if ({req_l, req_r} !== 2'b11) $display("FAIL reset_req: got %b expected 11", {req_l, req_r}); else n_pass++;
        n_total++; if (underrun !== 1'b0) $display("FAIL reset_unr: got %b expected 0", underrun); else n_pass++;
        resl = 1'b1; en = 1'b0;
        step();
    endtask

    task automatic test_basic_frame();
        logic [31:0] bits; int wsr, sckb; logic ul;
        ldata = 16'hA5C3; rdata = 16'h0F0F; wr_l = 1'b1; wr_r = 1'b1;
        step();
        wr_l = 1'b0; wr_r = 1'b0;
        n_total++; if ({req_l, req_r} !== 2'b00) $display("FAIL write_req: got %b expected 00", {req_l, req_r}); else n_pass++;
        en = 1'b1;
        step();
        n_total++; if (sck !== 1'b0) $display("FAIL entry_sck: got %b expected 0", sck); else n_pass++;
        n_total++; if (sdo !== ~I2S) $display("FAIL entry_sdo: got %b expected %b", sdo, ~I2S); else n_pass++;
        n_total++; if (req_l !== 1'b1) $display("FAIL entry_req_l: got %b expected 1", req_l); else n_pass++;
        n_total++; if (req_r !== 1'b0) $display("FAIL entry_req_r: got %b expected 0", req_r); else n_pass++;
        capture_frame(-1, bits, wsr, sckb, ul);
        n_total++; if (bits !== exp_frame(1'b0, 16'hA5C3, 16'h0F0F))
            $display("FAIL frame1_data: got %h expected %h", bits, exp_frame(1'b0, 16'hA5C3, 16'h0F0F)); else n_pass++;
        n_total++; if (wsr !== 64) $display("FAIL frame1_ws_rise: got %0d expected 64", wsr); else n_pass++;
        n_total++; if (sckb !== 0) $display("FAIL frame1_sck: got %0d bad cycles expected 0", sckb); else n_pass++;
        n_total++; if (ul !== 1'b0) $display("FAIL frame1_unr: got %b expected 0", ul); else n_pass++;
        n_total++; if (req_r !== 1'b1) $display("FAIL frame1_req_r: got %b expected 1", req_r); else n_pass++;
    endtask

    task automatic test_underrun();
        logic [31:0] bits; int wsr, sckb; logic ul;
        n_total++; if (underrun !== 1'b1) $display("FAIL unr_set: got %b expected 1", underrun); else n_pass++;
        capture_frame(-1, bits, wsr, sckb, ul);
        n_total++; if (bits !== exp_frame(1'b1, 16'hA5C3, 16'h0F0F))
            $display("FAIL frame2_data: got %h expected %h", bits, exp_frame(1'b1, 16'hA5C3, 16'h0F0F)); else n_pass++;
        n_total++; if (wsr !== 64) $display("FAIL frame2_ws_rise: got %0d expected 64", wsr); else n_pass++;
        repeat (100) step();
        unr_clr = 1'b1;
        step();
        unr_clr = 1'b0;
        n_total++; if (underrun !== 1'b0) $display("FAIL unr_clr: got %b expected 0", underrun); else n_pass++;
    endtask

    task automatic test_coincident();
        logic [31:0] bits; int wsr, sckb; logic ul;
        repeat (26) step();
        n_total++; if (req_l !== 1'b1) $display("FAIL coin_pre_req_l: got %b expected 1", req_l); else n_pass++;
        ldata = 16'h1234; wr_l = 1'b1; unr_clr = 1'b1;
        step();
        wr_l = 1'b0; unr_clr = 1'b0;
        n_total++; if (underrun !== 1'b1) $display("FAIL coin_unr: got %b expected 1", underrun); else n_pass++;
        n_total++; if (req_l !== 1'b0) $display("FAIL coin_req_l: got %b expected 0", req_l); else n_pass++;
        capture_frame(-1, bits, wsr, sckb, ul);
        n_total++; if (bits !== exp_frame(1'b1, 16'hA5C3, 16'h0F0F))
            $display("FAIL coin_old_word: got %h expected %h", bits, exp_frame(1'b1, 16'hA5C3, 16'h0F0F)); else n_pass++;
    endtask

    task automatic test_disable();
        logic [31:0] bits; int wsr, sckb, idle_bad;
        logic ul;
        capture_frame(20, bits, wsr, sckb, ul);
        n_total++; if (bits !== exp_frame(1'b1, 16'h1234, 16'h0F0F))
            $display("FAIL dis_frame_data: got %h expected %h", bits, exp_frame(1'b1, 16'h1234, 16'h0F0F)); else n_pass++;
        n_total++; if (sckb !== 0) $display("FAIL dis_frame_sck: got %0d bad cycles expected 0", sckb); else n_pass++;
        idle_bad = 0;
        for (int i = 0; i < 8; i++) begin
            if ({sck, ws, sdo} !== 3'b000) idle_bad++;
            step();
        end
        n_total++; if (idle_bad !== 0) $display("FAIL dis_idle_outputs: got %0d bad cycles expected 0", idle_bad); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic exp_sdo;
        // Slot 10 of 16'h1234 is bit 5 (1); the delayed build shows slot 9, bit 6 (0).
        exp_sdo = I2S ? 1'b0 : 1'b1;
        rdata = 16'hCAFE; wr_r = 1'b1;
        step();
        wr_r = 1'b0; en = 1'b1;
        step();
        n_total++; if (underrun !== 1'b1) $display("FAIL mid_entry_unr: got %b expected 1", underrun); else n_pass++;
        repeat (42) step();
        n_total++; if ({sck, ws, sdo} !== {2'b10, exp_sdo})
            $display("FAIL mid_slot10: got %b expected %b", {sck, ws, sdo}, {2'b10, exp_sdo}); else n_pass++;
        n_total++; if (req_r !== 1'b0) $display("FAIL mid_req_r: got %b expected 0", req_r); else n_pass++;
        resl = 1'b0;
        step();
        n_total++; if ({sck, ws, sdo} !== 3'b000) $display("FAIL mid_rst_out: got %b expected 000", {sck, ws, sdo}); else n_pass++;
        n_total++; if ({req_l, req_r, underrun} !== 3'b110)
            $display("FAIL mid_rst_flags: got %b expected 110", {req_l, req_r, underrun}); else n_pass++;
        resl = 1'b1; en = 1'b0;
        step();
        n_total++; if ({sck, sdo} !== 2'b00) $display("FAIL mid_post_rst: got %b expected 00", {sck, sdo}); else n_pass++;
    endtask

    initial begin
        resl = 1'b0; ldata = '0; rdata = '0; wr_l = 1'b0; wr_r = 1'b0;
        en = 1'b0; unr_clr = 1'b0; sdiv = 8'd1;
        test_reset();
        test_basic_frame();
        test_underrun();
        test_coincident();
        test_disable();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
